xge_pkt_gen: RTL and testbench
==============================

Name: xge_pkt_gen

Overview:
Parametrised synthesizable packet traffic generator driving the MAC transmit packet interface (pkt_tx_*) in the 156.25 MHz domain. Replaces per-test hand-driven stimulus for loopback and throughput runs. Generalises in bus width and length range, and adds programmable packet count, inter-packet gap, payload mode and pkt_tx_full backpressure handling.

Parameters:
DATA_W, 64, packet bus width in bits; multiple of 32, at least 64; BYTES = DATA_W/8.
MOD_W, $clog2(DATA_W/8), width of pkt_tx_mod (derived, not overridden).
MIN_LEN, 64, minimum packet length in bytes; cfg_len is clamped up to this.
MAX_LEN, 1518, maximum packet length in bytes; cfg_len is clamped down to this.
CNT_W, 16, width of the packet counters.

Ports:
clk_156m25  in  1  core clock
reset_156m25_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run, ignored while busy
stop  in  1  one-cycle pulse; ends the run at the next packet boundary
cfg_len  in  16  packet length in bytes; latched at start
cfg_count  in  CNT_W  packets per run; latched at start; 0 = continuous
cfg_gap  in  8  idle cycles between eop and next sop; latched at start
cfg_mode  in  1  payload: 0 incrementing bytes, 1 PRBS; latched at start
busy  out  1  run in progress
done  out  1  one-cycle pulse when a run ends
pkt_cnt  out  CNT_W  packets completed in the current or last run
pkt_tx_full  in  1  MAC transmit FIFO full
pkt_tx_val  out  1  word valid
pkt_tx_sop  out  1  first word of packet
pkt_tx_eop  out  1  last word of packet
pkt_tx_mod  out  MOD_W  valid bytes in eop word; 0 = all BYTES valid
pkt_tx_data  out  DATA_W  data; first byte in [DATA_W-1:DATA_W-8]

Behaviour:
- Reset (async): all outputs 0; FSM IDLE; PRBS state 32'hFFFF_FFFF. Reset mid-packet drops the packet, with no eop.
- All outputs are registered.
- Latched length: L = clamp(cfg_len, MIN_LEN, MAX_LEN).
  - Words per packet W = ceil(L/BYTES).
  - Eop pkt_tx_mod = L mod BYTES.
- FSM states: IDLE, DATA, GAP.
  - IDLE: on start, latch config, clear pkt_cnt, set busy, go to DATA. If start and stop arrive together, stop wins: no run, no done.
  - DATA: issue W words. sop on word 0, eop on word W-1. W=1 is impossible because MIN_LEN is at least BYTES.
    - On eop, increment pkt_cnt.
    - If count is reached (cfg_count != 0 and pkt_cnt+1 == cfg_count) or stop is pending, go to IDLE, clear busy, pulse done the same cycle.
    - Otherwise, if cfg_gap == 0, go to DATA with the next sop issued the cycle after eop.
    - Otherwise go to GAP.
  - GAP: hold val=0 for exactly cfg_gap cycles, then go to DATA. Stop pending in GAP goes to IDLE with done.
- stop: recorded as pending. A packet in progress always completes; no truncated packets.
- Backpressure:
  - A word is issued in cycle t+1 only if pkt_tx_full=0 in cycle t. Otherwise val=0 and the FSM and payload state hold.
  - The downstream must absorb one word after full rises.
  - GAP cycles count regardless of full.
- Incrementing mode: byte k of packet n = (n[7:0] + k) mod 256.
- PRBS mode:
  - 32-bit Fibonacci LFSR, x^32+x^22+x^2+x+1, advanced once per issued word.
  - Word = LFSR state replicated DATA_W/32 times.
  - State persists across packets and is reseeded to all-ones at start.
- Unused bytes of the eop word are 0.
- pkt_cnt wraps at 2^CNT_W in continuous mode.
- Config inputs are ignored except at start.

Optional Feature:
XGE_PKT_GEN_SEQNUM_EN
- Defined: bytes 0..3 of every packet carry the 32-bit packet index (0-based within the run, big-endian), overriding the payload mode. The PRBS mode still advances the LFSR on that word.
- Undefined: payload purely per cfg_mode; no sequence logic is synthesized.

Decomposition:
- Package xge_pkt_gen_pkg:
  - state enum {IDLE, DATA, GAP}
  - PRBS polynomial/seed constants
  - mode encoding constants
  - ceil-div helper function
- One sub-module, xge_prbs32: LFSR with seed-load and advance enable.
- FSM, counters and data mux stay in xge_pkt_gen.

Test Plan:
1. DATA_W=64, cfg_len=64, cfg_count=3, cfg_gap=0, mode 0, full=0 -> 24 consecutive valid words. sop at words 0/8/16, eop at 7/15/23, mod=0. Packet 1 byte 0 = 8'h01. done one cycle with eop 3, pkt_cnt=3.
2. cfg_len=67, cfg_count=1 -> 9 words, eop mod=3, eop bytes 3..7 zero. cfg_len=20 -> clamped to 64 (8 words). cfg_len=2000 -> 1518 bytes (190 words, mod=6).
3. cfg_gap=5, cfg_count=2 -> exactly 5 val=0 cycles between eop and next sop.
4. Mode 1, full pulsed high 3 cycles mid-packet -> at most one word after full rises, then val=0 for the remaining high cycles. Word sequence equals the reference LFSR sequence with no skipped or duplicated word.
5. cfg_count=0, stop at word 4 of packet 2 -> packet 2 completes (eop issued), done pulses, busy falls, no further sop. start+stop together in IDLE -> nothing.
6. Reset asserted mid-packet -> outputs 0 asynchronously. After release, start produces a fresh run with pkt_cnt=0, PRBS reseeded. With XGE_PKT_GEN_SEQNUM_EN, packet 2 bytes 0..3 = 00 00 00 02.

Source files
------------

// File: rtl/xge_pkt_gen_pkg.sv
// Shared types and constants for the xge_pkt_gen traffic generator.
// Used by xge_pkt_gen and xge_prbs32.
package xge_pkt_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        GAP  = 2'd2
    } state_e;

    // x^32 + x^22 + x^2 + x + 1 : taps at bits 31, 21, 1, 0
    localparam logic [31:0] PRBS_TAPS = 32'h8020_0003;
    localparam logic [31:0] PRBS_SEED = 32'hFFFF_FFFF;

    localparam logic MODE_INC  = 1'b0;
    localparam logic MODE_PRBS = 1'b1;

    function automatic logic [15:0] ceil_div(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [31:0] q;
        q = (32'(a) + 32'(b) - 32'd1) / 32'(b);
        return q[15:0];
    endfunction

endpackage

// File: rtl/xge_prbs32.sv
// 32-bit Fibonacci LFSR payload source for xge_pkt_gen.
// Seed load has priority over advance.
module xge_prbs32
    import xge_pkt_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        adv,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    // next LFSR state: reseed, shift in the tap parity, or hold
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = PRBS_SEED;
        end else if (adv) begin
            state_d = {state_q[30:0], ^(state_q & PRBS_TAPS)};
        end
    end

    // LFSR register, all-ones out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PRBS_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/xge_pkt_gen.sv
// Packet traffic generator for the MAC pkt_tx_* interface.
// Optional macro XGE_PKT_GEN_SEQNUM_EN: packet index in bytes 0..3.
module xge_pkt_gen
    import xge_pkt_gen_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int MOD_W   = $clog2(DATA_W/8),
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25_n,
    input  logic              start,
    input  logic              stop,
    input  logic [15:0]       cfg_len,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [7:0]        cfg_gap,
    input  logic              cfg_mode,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkt_cnt,
    input  logic              pkt_tx_full,
    output logic              pkt_tx_val,
    output logic              pkt_tx_sop,
    output logic              pkt_tx_eop,
    output logic [MOD_W-1:0]  pkt_tx_mod,
    output logic [DATA_W-1:0] pkt_tx_data
);

    localparam int BYTES = DATA_W / 8;
    localparam int REP   = DATA_W / 32;

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               stop_pend_q, stop_pend_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        words_q, words_d;
    logic [15:0]        word_idx_q, word_idx_d;
    logic [MOD_W-1:0]   last_mod_q, last_mod_d;
    logic [7:0]         gap_q, gap_d;
    logic [7:0]         gap_cnt_q, gap_cnt_d;
    logic               val_q, val_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic [MOD_W-1:0]   mod_q, mod_d;
    logic [DATA_W-1:0]  data_q, data_d;
`ifdef XGE_PKT_GEN_SEQNUM_EN
    logic [31:0]        seq_q, seq_d;
`endif

    logic               prbs_load;
    logic               prbs_adv;
    logic [31:0]        prbs;
    logic [15:0]        len_c;
    logic               last_word;
    logic               count_hit;
    logic               end_run;
    logic [DATA_W-1:0]  word;
    logic [15:0]        byte_off;
    logic [7:0]         byte_base;

    xge_prbs32 u_prbs (
        .clk   (clk_156m25),
        .rst_n (reset_156m25_n),
        .load  (prbs_load),
        .adv   (prbs_adv),
        .state (prbs)
    );

    assign last_word = (word_idx_q == words_q - 16'd1);
    assign count_hit = (count_q != '0) &&
                       (pkt_cnt_q + CNT_W'(1) == count_q);
    assign end_run   = count_hit || stop_pend_q || stop;

    // clamp the requested length into the supported range
    always_comb begin
        len_c = cfg_len;
        if (cfg_len < 16'(MIN_LEN)) begin
            len_c = 16'(MIN_LEN);
        end else if (cfg_len > 16'(MAX_LEN)) begin
            len_c = 16'(MAX_LEN);
        end
    end

    // payload word for the current word index and mode
    always_comb begin
        word      = '0;
        byte_off  = word_idx_q * 16'(BYTES);
        byte_base = pkt_cnt_q[7:0] + byte_off[7:0];
        for (int j = 0; j < BYTES; j++) begin
            word[DATA_W-1-8*j -: 8] = byte_base + 8'(j);
        end
        if (mode_q == MODE_PRBS) begin
            word = {REP{prbs}};
        end
`ifdef XGE_PKT_GEN_SEQNUM_EN
        if (word_idx_q == '0) begin
            word[DATA_W-1 -: 32] = seq_q;
        end
`endif
        if (last_word && last_mod_q != '0) begin
            for (int j = 0; j < BYTES; j++) begin
                if (j >= int'(last_mod_q)) begin
                    word[DATA_W-1-8*j -: 8] = 8'h00;
                end
            end
        end
    end

    // run FSM, counters and next registered bus word
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;
        mode_d      = mode_q;
        pkt_cnt_d   = pkt_cnt_q;
        count_d     = count_q;
        words_d     = words_q;
        word_idx_d  = word_idx_q;
        last_mod_d  = last_mod_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        val_d       = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        mod_d       = '0;
        data_d      = '0;
        prbs_load   = 1'b0;
        prbs_adv    = 1'b0;
`ifdef XGE_PKT_GEN_SEQNUM_EN
        seq_d       = seq_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d     = DATA;
                    busy_d      = 1'b1;
                    stop_pend_d = 1'b0;
                    mode_d      = cfg_mode;
                    pkt_cnt_d   = '0;
                    count_d     = cfg_count;
                    words_d     = ceil_div(len_c, 16'(BYTES));
                    last_mod_d  = MOD_W'(len_c % 16'(BYTES));
                    gap_d       = cfg_gap;
                    word_idx_d  = '0;
                    prbs_load   = 1'b1;
`ifdef XGE_PKT_GEN_SEQNUM_EN
                    seq_d       = '0;
`endif
                end
            end
            DATA: begin
                stop_pend_d = stop_pend_q | stop;
                if (!pkt_tx_full) begin
                    val_d      = 1'b1;
                    sop_d      = (word_idx_q == '0);
                    eop_d      = last_word;
                    data_d     = word;
                    prbs_adv   = 1'b1;
                    word_idx_d = word_idx_q + 16'd1;
                    if (last_word) begin
                        mod_d      = last_mod_q;
                        word_idx_d = '0;
                        pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
`ifdef XGE_PKT_GEN_SEQNUM_EN
                        seq_d      = seq_q + 32'd1;
`endif
                        if (end_run) begin
                            state_d     = IDLE;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end else if (gap_q == '0) begin
                            state_d = DATA;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q;
                        end
                    end
                end
            end
            GAP: begin
                if (stop || stop_pend_q) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                end else if (gap_cnt_q <= 8'd1) begin
                    state_d = DATA;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            mode_q      <= MODE_INC;
            pkt_cnt_q   <= '0;
            count_q     <= '0;
            words_q     <= '0;
            word_idx_q  <= '0;
            last_mod_q  <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            val_q       <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            mod_q       <= '0;
            data_q      <= '0;
`ifdef XGE_PKT_GEN_SEQNUM_EN
            seq_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
            mode_q      <= mode_d;
            pkt_cnt_q   <= pkt_cnt_d;
            count_q     <= count_d;
            words_q     <= words_d;
            word_idx_q  <= word_idx_d;
            last_mod_q  <= last_mod_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            val_q       <= val_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            mod_q       <= mod_d;
            data_q      <= data_d;
`ifdef XGE_PKT_GEN_SEQNUM_EN
            seq_q       <= seq_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign pkt_tx_val  = val_q;
    assign pkt_tx_sop  = sop_q;
    assign pkt_tx_eop  = eop_q;
    assign pkt_tx_mod  = mod_q;
    assign pkt_tx_data = data_q;

endmodule

// File: tb/tb_xge_pkt_gen.sv
// Self-checking bench for xge_pkt_gen (DATA_W=64).
// Expected streams come from a byte-level model of each run.
module tb_xge_pkt_gen;

    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [15:0]   cfg_len = '0;
    logic [CW-1:0] cfg_count = '0;
    logic [7:0]    cfg_gap = '0;
    logic          cfg_mode = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] pkt_cnt;
    logic          full = 1'b0;
    logic          val;
    logic          sop;
    logic          eop;
    logic [2:0]    mod;
    logic [DW-1:0] data;

    xge_pkt_gen dut (
        .clk_156m25     (clk),
        .reset_156m25_n (rst_n),
        .start          (start),
        .stop           (stop),
        .cfg_len        (cfg_len),
        .cfg_count      (cfg_count),
        .cfg_gap        (cfg_gap),
        .cfg_mode       (cfg_mode),
        .busy           (busy),
        .done           (done),
        .pkt_cnt        (pkt_cnt),
        .pkt_tx_full    (full),
        .pkt_tx_val     (val),
        .pkt_tx_sop     (sop),
        .pkt_tx_eop     (eop),
        .pkt_tx_mod     (mod),
        .pkt_tx_data    (data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          val;
        logic          sop;
        logic          eop;
        logic [2:0]    mod;
        logic [DW-1:0] data;
        logic          done;
        logic          busy;
        logic [CW-1:0] cnt;
        logic          full;
    } smp_t;

    typedef struct {
        logic          sop;
        logic          eop;
        logic [2:0]    mod;
        logic [DW-1:0] data;
    } ew_t;

    smp_t tr[$];
    ew_t  exp_q[$];
    ew_t  obs_q[$];
    int   vcyc_q[$];
    bit   cap = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        if (cap) begin
            tr.push_back('{val, sop, eop, mod, data, done, busy, pkt_cnt, full});
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int clamp_len(input int l);
        if (l < 64) return 64;
        if (l > 1518) return 1518;
        return l;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ^(s & 32'h8020_0003)};
    endfunction

    // byte-level model of one whole run
    task automatic build_exp(input int len, input int npk, input bit m);
        logic [31:0]   s;
        logic [DW-1:0] d;
        logic [7:0]    b;
        int            nw;
        int            k;
        s = 32'hFFFF_FFFF;
        nw = (len + 7) / 8;
        exp_q.delete();
        for (int n = 0; n < npk; n++) begin
            for (int w = 0; w < nw; w++) begin
                d = '0;
                for (int j = 0; j < 8; j++) begin
                    k = w * 8 + j;
                    if (m) b = s[31 - 8 * (j % 4) -: 8];
                    else   b = 8'(n + k);
`ifdef XGE_PKT_GEN_SEQNUM_EN
                    if (k < 4) b = 8'(n >> (8 * (3 - k)));
`endif
                    if (k >= len) b = 8'h00;
                    d[DW-1-8*j -: 8] = b;
                end
                exp_q.push_back('{w == 0, w == nw - 1,
                    (w == nw - 1) ? 3'(len % 8) : 3'd0, d});
                s = lfsr_next(s);
            end
        end
    endtask

    task automatic do_run(input int len, input int cnt, input int gap,
                          input bit m, input int full_pct,
                          input int pulse_at, input int stop_at);
        int nv = 0;
        int pl = 0;
        int pa = pulse_at;
        int sa = stop_at;
        int extra = 0;
        int cyc = 0;
        bit seen = 1'b0;
        tr.delete();
        cap = 1'b1;
        @(posedge clk); #1;
        cfg_len   = len[15:0];
        cfg_count = cnt[CW-1:0];
        cfg_gap   = gap[7:0];
        cfg_mode  = m;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        cfg_len   = 16'($urandom);
        cfg_count = CW'($urandom);
        cfg_gap   = 8'($urandom);
        cfg_mode  = ~m;
        while (extra < 4 && cyc < 6000) begin
            @(posedge clk); #1;
            cyc++;
            if (tr[$].val) nv++;
            if (seen) extra++;
            else if (tr[$].done) seen = 1'b1;
            if (pa >= 0 && nv >= pa) begin
                pl = 3;
                pa = -1;
            end
            full = (pl > 0) || ($urandom_range(0, 99) < full_pct);
            if (pl > 0) pl--;
            if (sa >= 0 && nv >= sa) begin
                stop = 1'b1;
                sa = -1;
            end else begin
                stop = 1'b0;
            end
        end
        stop = 1'b0;
        full = 1'b0;
        cap = 1'b0;
        chki("run_done_seen", int'(seen), 1);
    endtask

    task automatic check_run(input string nm, input int len, input int npk,
                             input int gap, input bit m, input bit chk_gap);
        int L;
        int nd = 0;
        int di = 0;
        int bp = 0;
        int gv = 0;
        int post = 0;
        int nmin;
        L = clamp_len(len);
        build_exp(L, npk, m);
        obs_q.delete();
        vcyc_q.delete();
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i].val) begin
                obs_q.push_back('{tr[i].sop, tr[i].eop, tr[i].mod, tr[i].data});
                vcyc_q.push_back(i);
            end
            if (tr[i].done) begin
                nd++;
                di = i;
            end
            if (i > 0 && tr[i].val && tr[i-1].full) bp++;
        end
        chki({nm, "_nwords"}, obs_q.size(), exp_q.size());
        nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            chk($sformatf("%s_w%0d", nm, i),
                72'({obs_q[i].sop, obs_q[i].eop, obs_q[i].mod, obs_q[i].data}),
                72'({exp_q[i].sop, exp_q[i].eop, exp_q[i].mod, exp_q[i].data}));
        end
        chki({nm, "_bp"}, bp, 0);
        chki({nm, "_ndone"}, nd, 1);
        chki({nm, "_done_at_eop"}, di, (vcyc_q.size() > 0) ? vcyc_q[$] : -1);
        chki({nm, "_busy_at_done"}, int'(tr[di].busy), 0);
        chki({nm, "_cnt_at_done"}, int'(tr[di].cnt), npk);
        for (int i = di + 1; i < tr.size(); i++) begin
            if (tr[i].sop || tr[i].val) post++;
        end
        chki({nm, "_post_done"}, post, 0);
        if (chk_gap) begin
            for (int k = 1; k < vcyc_q.size(); k++) begin
                if (vcyc_q[k] - vcyc_q[k-1] - 1 != (obs_q[k-1].eop ? gap : 0))
                    gv++;
            end
            chki({nm, "_gaps"}, gv, 0);
        end
    endtask

    initial begin
        int c;
        int nv;
        int nd;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 72'(data), 72'(0));
        chk("rst_ctl", 72'({val, sop, eop, mod, busy, done, pkt_cnt}), 72'(0));
        rst_n = 1'b1;

        // three back-to-back minimum packets
        do_run(64, 3, 0, 1'b0, 0, -1, -1);
        check_run("t1", 64, 3, 0, 1'b0, 1'b1);
        chk("t1_p1b0", 72'(obs_q[8].data[63:56]), 72'(8'h01));

        // length edge cases
        do_run(67, 1, 0, 1'b0, 0, -1, -1);
        check_run("t2a", 67, 1, 0, 1'b0, 1'b1);
        chk("t2a_mod", 72'(obs_q[$].mod), 72'(3));
        do_run(20, 1, 0, 1'b0, 0, -1, -1);
        check_run("t2b", 20, 1, 0, 1'b0, 1'b1);
        chki("t2b_words", obs_q.size(), 8);
        do_run(2000, 1, 0, 1'b1, 0, -1, -1);
        check_run("t2c", 2000, 1, 0, 1'b1, 1'b1);
        chki("t2c_words", obs_q.size(), 190);
        chk("t2c_mod", 72'(obs_q[$].mod), 72'(6));

        // inter-packet gap
        do_run(64, 2, 5, 1'b0, 0, -1, -1);
        check_run("t3", 64, 2, 5, 1'b0, 1'b1);
        chki("t3_gap", vcyc_q[8] - vcyc_q[7] - 1, 5);

        // backpressure pulse in PRBS mode
        do_run(128, 2, 2, 1'b1, 0, 5, -1);
        check_run("t4", 128, 2, 2, 1'b1, 1'b0);
        c = -1;
        for (int i = 0; i < tr.size(); i++) begin
            if (c < 0 && tr[i].full) c = i;
        end
        nv = 0;
        for (int i = c + 1; i <= c + 3 && i < tr.size(); i++) begin
            if (tr[i].val) nv++;
        end
        chki("t4_hold", nv, 0);

        // continuous run stopped in packet 2
        do_run(64, 0, 0, 1'b0, 0, -1, 2 * 8 + 5);
        check_run("t5", 64, 3, 0, 1'b0, 1'b1);

        // start and stop together from idle
        tr.delete();
        cap = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        cap = 1'b0;
        nv = 0;
        nd = 0;
        foreach (tr[i]) begin
            if (tr[i].val || tr[i].busy) nv++;
            if (tr[i].done) nd++;
        end
        chki("t5_ss_active", nv, 0);
        chki("t5_ss_done", nd, 0);

        // reset in the middle of a packet
        @(posedge clk); #1;
        cfg_len = 16'd256;
        cfg_count = '0;
        cfg_gap = 8'd0;
        cfg_mode = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        chki("t6_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_data", 72'(data), 72'(0));
        chk("t6_rst_ctl", 72'({val, sop, eop, mod, busy, done, pkt_cnt}), 72'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_run(100, 3, 1, 1'b1, 0, -1, -1);
        check_run("t6", 100, 3, 1, 1'b1, 1'b1);
`ifdef XGE_PKT_GEN_SEQNUM_EN
        chk("t6_seq", 72'(obs_q[26].data[63:32]), 72'(32'h0000_0002));
`endif

        // randomized runs with random backpressure
        for (int r = 0; r < 6; r++) begin
            int len;
            int cnt;
            int gap;
            bit m;
            len = $urandom_range(20, 300);
            cnt = $urandom_range(1, 4);
            gap = $urandom_range(0, 4);
            m = 1'($urandom);
            do_run(len, cnt, gap, m, 25, -1, -1);
            check_run($sformatf("rnd%0d", r), len, cnt, gap, m, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
